// File: rtl/shift_pkg.sv
// Shared constants and helpers for the serial shift-chain blocks.
// Provides the default word width and the bit-counter width function.
package shift_pkg;

   localparam int DEF_WIDTH = 8;

   // Width of a counter that indexes bits 0..width-1 (never below 1 bit).
   function automatic int cnt_w(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/serial_deserializer_out_reg.sv
// One-deep output holding register for assembled words.
// Also carries the sticky overflow flag for words dropped while the register is full.
module deser_out_reg
   import shift_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] word,
   output logic [WIDTH-1:0] m_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic             overflow
);

   // Handshake: a word moves to the consumer on any posedge with m_valid & m_ready.
   // m_valid never drops without a transfer, and m_data is stable while m_valid=1.
   // m_ready has no effect while m_valid=0.
   logic transfer;

   assign transfer = m_valid & m_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_data   <= '0;
         m_valid  <= 1'b0;
         overflow <= 1'b0;
      end else begin
         if (load) begin
            // A full register that is not draining this edge cannot accept the word.
            if (m_valid && !transfer) begin
               overflow <= 1'b1;
            end else begin
               m_data  <= word;
               m_valid <= 1'b1;
            end
         end else if (transfer) begin
            m_valid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/serial_deserializer.sv
// Serial-to-parallel receiver: shifts qualified bits into a word and hands
// each completed word to a one-deep valid/ready output register.
module serial_deserializer
   import shift_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s_valid,
   input  logic             s_data,
   input  logic             s_start,
   output logic [WIDTH-1:0] m_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic             overflow
);

   localparam int            CW   = cnt_w(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] ONE  = CW'(1);

   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] shreg_nxt;
   logic [CW-1:0]    cnt;
   logic [CW-1:0]    cnt_nxt;
   logic             word_done;

   always_comb begin
      shreg_nxt = shreg;
      cnt_nxt   = cnt;
      word_done = 1'b0;
      if (s_valid) begin
         if (MSB_FIRST) begin
            shreg_nxt = {shreg[WIDTH-2:0], s_data};
         end else begin
            shreg_nxt = {s_data, shreg[WIDTH-1:1]};
         end
         // A frame start restarts counting; stale bits simply shift out later.
         if (s_start) begin
            cnt_nxt = ONE;
         end else if (cnt == LAST) begin
            cnt_nxt   = '0;
            word_done = 1'b1;
         end else begin
            cnt_nxt = cnt + ONE;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg <= '0;
         cnt   <= '0;
      end else begin
         shreg <= shreg_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // The completed word includes the bit sampled on this same edge.
   deser_out_reg #(
      .WIDTH (WIDTH)
   ) u_out_reg (
      .clk      (clk),
      .rst      (rst),
      .load     (word_done),
      .word     (shreg_nxt),
      .m_data   (m_data),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .overflow (overflow)
   );

endmodule

// File: tb/tb_serial_deserializer.sv
// Directed bench for serial_deserializer: an MSB-first and an LSB-first
// instance share one input stream and one m_ready.
module tb_serial_deserializer;

   logic       clk;
   logic       rst;
   logic       s_valid;
   logic       s_data;
   logic       s_start;
   logic       m_ready;
   logic [7:0] m_data_a;
   logic       m_valid_a;
   logic       overflow_a;
   logic [7:0] m_data_b;
   logic       m_valid_b;
   logic       overflow_b;

   int n_checks = 0;
   int n_fail   = 0;

   serial_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_a (
      .clk      (clk),
      .rst      (rst),
      .s_valid  (s_valid),
      .s_data   (s_data),
      .s_start  (s_start),
      .m_data   (m_data_a),
      .m_valid  (m_valid_a),
      .m_ready  (m_ready),
      .overflow (overflow_a)
   );

   serial_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_b (
      .clk      (clk),
      .rst      (rst),
      .s_valid  (s_valid),
      .s_data   (s_data),
      .s_start  (s_start),
      .m_data   (m_data_b),
      .m_valid  (m_valid_b),
      .m_ready  (m_ready),
      .overflow (overflow_b)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Driver tasks: inputs change 1 time unit after posedge, outputs sampled there too.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b, input logic st, input bit gap);
      if (gap) begin
         // Idle cycle with a stray s_start that must be ignored.
         s_valid = 1'b0;
         s_start = 1'b1;
         s_data  = 1'($urandom_range(1, 0));
         tick();
      end
      s_valid = 1'b1;
      s_data  = b;
      s_start = st;
      tick();
      s_valid = 1'b0;
      s_start = 1'b0;
   endtask

   // Sends w[7] first, with s_start on the first bit.
   task automatic send_word(input logic [7:0] w, input bit gaps, input bit rdy_last);
      for (int i = 7; i >= 0; i--) begin
         if (rdy_last && i == 0) m_ready = 1'b1;
         send_bit(w[i], (i == 7), gaps && (i != 7));
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [4:0] partial;
      rst     = 1'b1;
      s_valid = 1'b0;
      s_data  = 1'b0;
      s_start = 1'b0;
      m_ready = 1'b0;
      #3;
      check("reset m_valid_a", 32'(m_valid_a), 32'h0);
      check("reset m_data_a", 32'(m_data_a), 32'h0);
      check("reset overflow_a", 32'(overflow_a), 32'h0);
      check("reset m_valid_b", 32'(m_valid_b), 32'h0);
      tick();
      rst = 1'b0;

      // 1: async reset mid-stream with a held word and overflow set
      send_word(8'h3C, 1'b0, 1'b0);
      send_word(8'hC3, 1'b0, 1'b0);
      send_bit(1'b1, 1'b1, 1'b0);
      send_bit(1'b0, 1'b0, 1'b0);
      send_bit(1'b1, 1'b0, 1'b0);
      check("pre-reset overflow", 32'(overflow_a), 32'h1);
      #2;
      rst = 1'b1;
      #1;
      check("async rst m_valid", 32'(m_valid_a), 32'h0);
      check("async rst m_data", 32'(m_data_a), 32'h0);
      check("async rst overflow", 32'(overflow_a), 32'h0);
      check("async rst m_data_b", 32'(m_data_b), 32'h0);
      tick();
      rst = 1'b0;
      send_word(8'hA5, 1'b0, 1'b0);
      check("post-rst m_data", 32'(m_data_a), 32'hA5);
      check("post-rst m_valid", 32'(m_valid_a), 32'h1);
      check("post-rst overflow", 32'(overflow_a), 32'h0);
      m_ready = 1'b1;
      tick();
      check("post-rst drain", 32'(m_valid_a), 32'h0);

      // 2/3: 1,0,1,0,0,1,0,1 with m_ready=1, both bit orders
      send_word(8'hA5, 1'b0, 1'b0);
      check("msb A5 m_valid", 32'(m_valid_a), 32'h1);
      check("msb A5 m_data", 32'(m_data_a), 32'hA5);
      check("lsb A5 m_data", 32'(m_data_b), 32'hA5);
      tick();
      check("A5 one cycle", 32'(m_valid_a), 32'h0);
      send_word(8'h01, 1'b0, 1'b0);
      check("msb 01 m_data", 32'(m_data_a), 32'h01);
      check("lsb 01 m_data", 32'(m_data_b), 32'h80);
      tick();

      // 4: two words while m_ready=0
      m_ready = 1'b0;
      send_word(8'h3C, 1'b0, 1'b0);
      send_word(8'hC3, 1'b0, 1'b0);
      check("held m_data", 32'(m_data_a), 32'h3C);
      check("held m_valid", 32'(m_valid_a), 32'h1);
      check("overflow set", 32'(overflow_a), 32'h1);
      m_ready = 1'b1;
      tick();
      check("held drained", 32'(m_valid_a), 32'h0);
      check("overflow sticky", 32'(overflow_a), 32'h1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("overflow cleared", 32'(overflow_a), 32'h0);

      // 5: transfer and completion on the same edge
      m_ready = 1'b0;
      send_word(8'h11, 1'b0, 1'b0);
      check("b2b 11 m_data", 32'(m_data_a), 32'h11);
      check("b2b 11 m_valid", 32'(m_valid_a), 32'h1);
      send_word(8'h22, 1'b0, 1'b1);
      check("b2b 22 m_valid", 32'(m_valid_a), 32'h1);
      check("b2b 22 m_data", 32'(m_data_a), 32'h22);
      check("b2b overflow", 32'(overflow_a), 32'h0);
      check("b2b lsb m_data", 32'(m_data_b), 32'h44);
      tick();
      check("b2b drained", 32'(m_valid_a), 32'h0);

      // 6: partial word discarded by a new start, then again with gaps
      m_ready = 1'b0;
      for (int pass = 0; pass < 2; pass++) begin
         partial = 5'b10011;
         for (int i = 4; i >= 0; i--) send_bit(partial[i], (i == 4), 1'b0);
         check("partial no word", 32'(m_valid_a), 32'h0);
         send_word(8'h7E, (pass == 1), 1'b0);
         check("restart m_data", 32'(m_data_a), 32'h7E);
         check("restart m_valid", 32'(m_valid_a), 32'h1);
         check("restart overflow", 32'(overflow_a), 32'h0);
         check("restart lsb m_data", 32'(m_data_b), 32'h7E);
         m_ready = 1'b1;
         tick();
         check("restart drained", 32'(m_valid_a), 32'h0);
         m_ready = 1'b0;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
